// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch channel: valid/ready request plus a valid-only
// response. The fetch unit is the master; instruction memory is the slave.
interface pc_fetch_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for the sequential core. Fetches one
// instruction at a time, holds it for execute, then steps the PC by 4 or by
// the branch offset. A misaligned next PC parks the unit in a sticky trap.
module pc_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_if.master       imem,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [XLEN-1:0]  pc,
  input  logic             wb_done,
  input  logic             pc_sel,
  input  logic [XLEN-1:0]  branch_off,
  output logic             trap_misalign
);

  localparam logic [31:0]     NOP_INSTR   = 32'h0000_0013;
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_EXEC,
    S_TRAP
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            instr_valid_q;
  logic            req_valid_q;
  logic            trap_q;
  logic [XLEN-1:0] next_pc_d;

  // Candidate PC for the instruction after the current one (modulo 2^XLEN).
  always_comb begin
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    next_pc_d = pc_q + INSTR_BYTES;
    if (pc_sel) begin
      next_pc_d = pc_q + branch_off;
    end
  end

  // Fetch sequencer: state, PC, instruction register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      req_valid_q   <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q     <= S_REQ;
          req_valid_q <= 1'b1;
        end
        S_REQ: begin
          // Address and valid are held until memory accepts.
          if (imem.imem_req_ready) begin
            state_q     <= S_WAIT_RSP;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT_RSP: begin
          if (imem.imem_rsp_valid) begin
            instr_q       <= imem.imem_rsp_data;
            instr_valid_q <= 1'b1;
            state_q       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (wb_done) begin
            instr_valid_q <= 1'b0;
            if (next_pc_d[1:0] != 2'b00) begin
              // PC keeps the address of the offending branch.
              state_q <= S_TRAP;
              trap_q  <= 1'b1;
            end else begin
              pc_q        <= next_pc_d;
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        S_TRAP: begin
          // Parked until reset.
          state_q <= S_TRAP;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_addr      = pc_q;
  assign instr               = instr_q;
  assign instr_valid         = instr_valid_q;
  assign pc                  = pc_q;
  assign trap_misalign       = trap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized bench for pc_fetch_unit. The bench plays the
// instruction memory and the execute stage; a small model tracks the PC
// from the architectural rules (step by 4 or by offset, trap when misaligned).
module tb_pc_fetch_unit;

  localparam int XLEN = 64;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [63:0] pc;
  logic        wb_done = 1'b0;
  logic        pc_sel = 1'b0;
  logic [63:0] branch_off = '0;
  logic        trap_misalign;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [63:0] m_pc = RESET_PC;
  logic [31:0] m_instr = NOP_INSTR;

  pc_fetch_if #(.XLEN(XLEN)) bus ();

  pc_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (bus),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .wb_done      (wb_done),
    .pc_sel       (pc_sel),
    .branch_off   (branch_off),
    .trap_misalign(trap_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural next-PC rule, in plain arithmetic.
  function automatic logic [63:0] model_next(input logic sel, input logic [63:0] off,
                                             input logic [63:0] cur);
    return sel ? cur + off : cur + 64'd4;
  endfunction

  // Fetch one instruction: wait for the request, stall ready, then respond.
  task automatic fetch(input int rdy_wait, input int rsp_wait, input logic [31:0] word);
    int n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 64'(bus.imem_req_valid), 64'd1);
    chk("req_addr", bus.imem_addr, m_pc);
    for (int i = 0; i < rdy_wait; i++) begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'($urandom_range(0, 1));
      bus.imem_rsp_data  = $urandom;
      @(negedge clk);
      chk("stall_req_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("stall_addr", bus.imem_addr, m_pc);
      chk("stall_instr_valid", 64'(instr_valid), 64'd0);
    end
    // Accept cycle; a response in this same cycle must be dropped.
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'($urandom_range(0, 1));
    bus.imem_rsp_data  = ~word;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    chk("accept_req_drop", 64'(bus.imem_req_valid), 64'd0);
    chk("accept_no_instr", 64'(instr_valid), 64'd0);
    for (int i = 0; i < rsp_wait; i++) begin
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("wait_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("wait_instr_valid", 64'(instr_valid), 64'd0);
    end
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = word;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    m_instr = word;
    chk("exec_valid", 64'(instr_valid), 64'd1);
    chk("exec_instr", 64'(instr), 64'(m_instr));
    chk("exec_pc", pc, m_pc);
    chk("exec_no_req", 64'(bus.imem_req_valid), 64'd0);
  endtask

  // Hold in execute for a while with noise, then retire with a branch decision.
  task automatic retire(input int hold, input logic sel, input logic [63:0] off);
    logic [63:0] nxt;
    for (int i = 0; i < hold; i++) begin
      wb_done            = 1'b0;
      pc_sel             = 1'($urandom_range(0, 1));
      branch_off         = {$urandom, $urandom};
      bus.imem_rsp_valid = 1'($urandom_range(0, 1));
      bus.imem_rsp_data  = $urandom;
      @(negedge clk);
      chk("hold_valid", 64'(instr_valid), 64'd1);
      chk("hold_instr", 64'(instr), 64'(m_instr));
      chk("hold_pc", pc, m_pc);
      chk("hold_no_req", 64'(bus.imem_req_valid), 64'd0);
    end
    bus.imem_rsp_valid = 1'b0;
    wb_done    = 1'b1;
    pc_sel     = sel;
    branch_off = off;
    nxt = model_next(sel, off, m_pc);
    @(negedge clk);
    wb_done = 1'b0;
    pc_sel  = 1'b0;
    chk("retire_instr_valid", 64'(instr_valid), 64'd0);
    if (nxt % 64'd4 != 64'd0) begin
      chk("trap_flag", 64'(trap_misalign), 64'd1);
      chk("trap_pc_kept", pc, m_pc);
      chk("trap_no_req", 64'(bus.imem_req_valid), 64'd0);
    end else begin
      m_pc = nxt;
      chk("next_req", 64'(bus.imem_req_valid), 64'd1);
      chk("next_addr", bus.imem_addr, m_pc);
      chk("no_trap", 64'(trap_misalign), 64'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd0);
    chk({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_instr"}, 64'(instr), 64'(NOP_INSTR));
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_addr"}, bus.imem_addr, RESET_PC);
    chk({tag, "_trap"}, 64'(trap_misalign), 64'd0);
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;

    // Reset state, then first request exactly one cycle after release.
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    m_pc = RESET_PC;
    @(negedge clk);
    chk("first_req_cycle1", 64'(bus.imem_req_valid), 64'd1);
    chk("first_req_addr", bus.imem_addr, RESET_PC);
    fetch(0, 0, 32'h0050_0093);

    // Sequential and branch targets around 0x100.
    retire(1, 1'b1, 64'h100);
    fetch(0, 1, $urandom);
    retire(0, 1'b0, 64'h0);                 // 0x104
    chk("seq_0x104", m_pc, 64'h104);
    fetch(1, 0, $urandom);
    retire(2, 1'b1, -64'sd4);               // back to 0x100
    fetch(0, 0, $urandom);
    retire(0, 1'b1, -64'sd8);               // 0xF8
    chk("back_0xF8", m_pc, 64'hF8);
    fetch(0, 2, $urandom);
    retire(1, 1'b1, 64'h8);
    fetch(0, 0, $urandom);
    retire(0, 1'b1, 64'h20);                // 0x120
    chk("fwd_0x120", m_pc, 64'h120);

    // Ready held low for five cycles.
    fetch(5, 3, $urandom);
    retire(1, 1'b1, -64'sd32);              // 0x100
    fetch(0, 0, $urandom);

    // Misaligned branch: sticky trap, nothing fetched until reset.
    retire(1, 1'b1, 64'h6);
    for (int i = 0; i < 6; i++) begin
      wb_done            = 1'($urandom_range(0, 1));
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.imem_rsp_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trapped_no_req", 64'(bus.imem_req_valid), 64'd0);
      chk("trapped_flag", 64'(trap_misalign), 64'd1);
      chk("trapped_pc", pc, m_pc);
    end
    wb_done = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("trap_rst");
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RESET_PC;
    fetch(0, 0, $urandom);

    // Top-of-address-space wrap.
    retire(0, 1'b1, -64'sd4);
    chk("top_pc", m_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(1, 1, $urandom);
    retire(0, 1'b0, 64'h0);
    chk("wrap_zero", m_pc, 64'h0);
    fetch(0, 0, $urandom);

    // Randomized fetch/execute traffic with aligned offsets.
    for (int it = 0; it < 40; it++) begin
      longint o;
      o = (longint'($urandom_range(0, 511)) - 256) * 4;
      retire($urandom_range(0, 3), 1'($urandom_range(0, 1)), 64'(o));
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset while waiting for a response; the late response never arrives.
    retire(0, 1'b0, 64'h0);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    chk("mid_wait_state", 64'(bus.imem_req_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = RESET_PC;
    chk("mid_idle_no_req", 64'(bus.imem_req_valid), 64'd0);
    fetch(0, 0, 32'hDEAD_BEEF);
    retire(1, 1'b0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
